ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader_pkg.sv | 34 +++
 rtl/ram_stream_reader_fifo.sv | 72 +++++++
 rtl/ram_stream_reader.sv | 181 ++++++++++++++++++
 tb/tb_ram_stream_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg
//   Shared definitions for the RAM stream reader and the SD loader that fills
//   the same double-buffered sample RAM.
//   - rsr_state_t        : reader FSM state encoding
//   - RSR_HALF_WORDS_DEF : default words per buffer half
//   - RSR_UPPER_BASE_DEF : default RAM word address of the upper half
//   - rsr_word_addr()    : maps (half, offset) to a RAM word address
`timescale 1ns/1ps
package ram_stream_reader_pkg;

    typedef enum logic [2:0] {
        ST_PRIME     = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_HOLD      = 3'd3,
        ST_SWAP_WAIT = 3'd4
    } rsr_state_t;

    localparam int          RSR_ADDR_W         = 25;
    localparam int          RSR_DATA_W         = 16;
    localparam logic [23:0] RSR_HALF_WORDS_DEF = 24'h800000;
    localparam logic [24:0] RSR_UPPER_BASE_DEF = 25'h0800000;
    localparam int          RSR_FIFO_DEPTH_DEF = 4;

    // Lower half starts at word 0; upper half starts at the given base.
    function automatic logic [RSR_ADDR_W-1:0] rsr_word_addr(
        input logic                  half,
        input logic [RSR_ADDR_W-1:0] upper_base,
        input logic [RSR_ADDR_W-1:0] offset
    );
        return half ? (upper_base + offset) : offset;
    endfunction

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// sample_fifo
//   Synchronous prefetch FIFO between the RAM read engine and the sample
//   output. Head entry is presented combinationally on o_rdata.
//   Ports:
//     clk50, reset  : clock / synchronous active-high reset
//     i_push,i_wdata: write an entry (dropped when full unless popping)
//     i_pop         : remove the head entry (ignored when empty)
//     o_rdata       : head entry
//     o_full/o_empty/o_count : occupancy status
`timescale 1ns/1ps
module sample_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int DEPTH = RSR_FIFO_DEPTH_DEF,
    parameter int WIDTH = RSR_DATA_W
)(
    input  logic                     clk50,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO can still accept a write when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk50) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Streams 16-bit audio samples out of a double-buffered RAM. The SD loader
//   fills one half while this block plays the other; halves swap once the
//   reader reaches the end of its half and the loader reports it has paused.
//   Reads are prefetched into a small FIFO, one outstanding read at a time,
//   and popped on each sample-rate tick.
//   Ports:
//     clk50, reset            : clock / synchronous active-high reset
//     enable                  : playback enable; low freezes reads and output
//     ram_re, ram_address     : read request / word address to the arbiter
//     ram_op_begun            : arbiter accepted the request (pulse)
//     ram_rdata(_valid)       : returned read data (pulse)
//     loader_paused           : loader finished its authorised half
//     fill_half               : half the loader may write
//     sample_tick             : sample-rate strobe
//     sample_out, sample_valid: current sample and its update pulse
//     underrun                : sticky, a tick found no data while playing
//     rd_half                 : half currently being read
`timescale 1ns/1ps
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter logic [23:0] HALF_WORDS = RSR_HALF_WORDS_DEF,
    parameter logic [24:0] UPPER_BASE = RSR_UPPER_BASE_DEF,
    parameter int          FIFO_DEPTH = RSR_FIFO_DEPTH_DEF
)(
    input  logic                  clk50,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  ram_re,
    output logic [RSR_ADDR_W-1:0] ram_address,
    input  logic                  ram_op_begun,
    input  logic [RSR_DATA_W-1:0] ram_rdata,
    input  logic                  ram_rdata_valid,
    input  logic                  loader_paused,
    output logic                  fill_half,
    input  logic                  sample_tick,
    output logic [RSR_DATA_W-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  underrun,
    output logic                  rd_half
);

    localparam int PTR_W = $clog2(HALF_WORDS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rsr_state_t            r_state;
    logic                  r_ram_re;
    logic [RSR_ADDR_W-1:0] r_ram_address;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  r_rd_half;
    logic                  r_fill_half;
    logic [RSR_DATA_W-1:0] r_sample_out;
    logic                  r_sample_valid;
    logic                  r_underrun;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_last_word;
    logic                  w_playing_tick;
    logic [RSR_DATA_W-1:0] w_fifo_rdata;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;

    // Data is only accepted while a read is outstanding; anything else
    // (including a read abandoned by reset) is a stray and dropped.
    assign w_push      = (r_state == ST_WAIT_DATA) && ram_rdata_valid;
    assign w_last_word = (r_rd_ptr == PTR_W'(HALF_WORDS - 24'd1));

    // Only ISSUE can raise a request and no read is outstanding there, so the
    // FIFO count alone covers the in-flight word once it lands.
    assign w_room = (w_fifo_count < CNT_W'(FIFO_DEPTH));

    // Ticks are meaningful only once playback has been primed.
    assign w_playing_tick = sample_tick && enable && (r_state != ST_PRIME);
    assign w_pop          = w_playing_tick && !w_fifo_empty;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RSR_DATA_W)
    ) u_fifo (
        .clk50   (clk50),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (ram_rdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Read engine FSM.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state       <= ST_PRIME;
            r_ram_re      <= 1'b0;
            r_ram_address <= '0;
            r_rd_ptr      <= '0;
            r_rd_half     <= 1'b0;
            r_fill_half   <= 1'b0;
        end else begin
            case (r_state)
                ST_PRIME: begin
                    // Half 0 is loaded; hand half 1 to the loader.
                    if (loader_paused) begin
                        r_fill_half <= 1'b1;
                        r_rd_half   <= 1'b0;
                        r_rd_ptr    <= '0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // An acceptance already on the wire wins over a late
                    // enable drop, otherwise the arbiter would run a read
                    // nobody is waiting for.
                    if (r_ram_re && ram_op_begun) begin
                        r_ram_re <= 1'b0;
                        r_state  <= ST_WAIT_DATA;
                    end else if (!enable) begin
                        r_ram_re <= 1'b0;
                        r_state  <= ST_HOLD;
                    end else if (!r_ram_re && w_room) begin
                        // Address is latched with the request so it stays
                        // stable for as long as ram_re is held.
                        r_ram_re      <= 1'b1;
                        r_ram_address <= rsr_word_addr(r_rd_half, UPPER_BASE,
                                                       RSR_ADDR_W'(r_rd_ptr));
                    end
                end
                ST_WAIT_DATA: begin
                    if (ram_rdata_valid) begin
                        // Pointer width equals log2(HALF_WORDS), so the last
                        // word of a half wraps it back to 0.
                        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                        r_state  <= w_last_word ? ST_SWAP_WAIT : ST_ISSUE;
                    end
                end
                ST_HOLD: begin
                    if (enable) r_state <= ST_ISSUE;
                end
                ST_SWAP_WAIT: begin
                    // Other half is filled; swap roles with the loader.
                    if (loader_paused) begin
                        r_rd_half   <= ~r_rd_half;
                        r_fill_half <= r_rd_half;
                        r_state     <= ST_ISSUE;
                    end
                end
                default: begin
                    r_ram_re <= 1'b0;
                    r_state  <= ST_PRIME;
                end
            endcase
        end
    end

    // Sample output path.
    always_ff @(posedge clk50) begin
        if (reset) begin
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_sample_valid <= w_pop;
            if (w_pop) r_sample_out <= w_fifo_rdata;
            if (w_playing_tick && w_fifo_empty) r_underrun <= 1'b1;
        end
    end

    assign ram_re       = r_ram_re;
    assign ram_address  = r_ram_address;
    assign fill_half    = r_fill_half;
    assign rd_half      = r_rd_half;
    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_ram_stream_reader.sv
`timescale 1ns/1ps
module tb_ram_stream_reader;

    localparam logic [23:0] HW = 24'd16;
    localparam logic [24:0] UB = 25'h0000100;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        ram_re;
    logic [24:0] ram_address;
    logic        ram_op_begun = 1'b0;
    logic [15:0] ram_rdata = 16'h0;
    logic        ram_rdata_valid = 1'b0;
    logic        loader_paused = 1'b0;
    logic        fill_half;
    logic        sample_tick = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        underrun;
    logic        rd_half;

    ram_stream_reader #(.HALF_WORDS(HW), .UPPER_BASE(UB), .FIFO_DEPTH(4)) dut (
        .clk50(clk50), .reset(reset), .enable(enable),
        .ram_re(ram_re), .ram_address(ram_address), .ram_op_begun(ram_op_begun),
        .ram_rdata(ram_rdata), .ram_rdata_valid(ram_rdata_valid),
        .loader_paused(loader_paused), .fill_half(fill_half),
        .sample_tick(sample_tick), .sample_out(sample_out),
        .sample_valid(sample_valid), .underrun(underrun), .rd_half(rd_half)
    );

    always #10 clk50 = ~clk50;

    int n_pass = 0;
    int n_chk  = 0;
    int lat    = 1;
    int n_up   = 0;

    // RAM/arbiter model: accepts a request one cycle after ram_re, returns
    // data = address[15:0] 'lat' cycles later. Also logs output samples.
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [24:0] addr_l = '0;
    int          n_valid = 0;
    int          n_re = 0;
    logic [15:0] got[$];

    always @(posedge clk50) begin
        #1;
        if (sample_valid) begin
            n_valid++;
            got.push_back(sample_out);
        end
        if (ram_re) n_re++;
        ram_op_begun    = 1'b0;
        ram_rdata_valid = 1'b0;
        if (busy) begin
            cnt--;
            if (cnt <= 0) begin
                ram_rdata_valid = 1'b1;
                ram_rdata       = addr_l[15:0];
                busy            = 1'b0;
            end
        end else if (ram_re) begin
            ram_op_begun = 1'b1;
            busy         = 1'b1;
            cnt          = lat;
            addr_l       = ram_address;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk50);
        #2;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
    endtask

    task automatic pause_pulse();
        loader_paused = 1'b1;
        cyc(1);
        loader_paused = 1'b0;
    endtask

    task automatic wait_re();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ram_re) begin ok = 1'b1; break; end
            cyc(1);
        end
        n_chk++;
        if (ok !== 1'b1) $display("FAIL wait_ram_re timeout got %0b exp 1", ok);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        n_chk++; if (ram_re !== 1'b0) $display("FAIL rst_ram_re got %0b exp 0", ram_re); else n_pass++;
        n_chk++; if (ram_address !== 25'h0) $display("FAIL rst_ram_address got %0h exp 0", ram_address); else n_pass++;
        n_chk++; if (fill_half !== 1'b0) $display("FAIL rst_fill_half got %0b exp 0", fill_half); else n_pass++;
        n_chk++; if (rd_half !== 1'b0) $display("FAIL rst_rd_half got %0b exp 0", rd_half); else n_pass++;
        n_chk++; if (sample_out !== 16'h0) $display("FAIL rst_sample_out got %0h exp 0", sample_out); else n_pass++;
        n_chk++; if (sample_valid !== 1'b0) $display("FAIL rst_sample_valid got %0b exp 0", sample_valid); else n_pass++;
        n_chk++; if (underrun !== 1'b0) $display("FAIL rst_underrun got %0b exp 0", underrun); else n_pass++;
    endtask

    task automatic test_prime_ticks();
        int v0, r0;
        v0 = n_valid; r0 = n_re;
        enable = 1'b1;
        repeat (10) begin tick(); cyc(1); end
        n_chk++; if (underrun !== 1'b0) $display("FAIL prime_underrun got %0b exp 0", underrun); else n_pass++;
        n_chk++; if (n_valid - v0 !== 0) $display("FAIL prime_valid got %0d exp 0", n_valid - v0); else n_pass++;
        n_chk++; if (n_re - r0 !== 0) $display("FAIL prime_ram_re got %0d exp 0", n_re - r0); else n_pass++;
        n_chk++; if (fill_half !== 1'b0) $display("FAIL prime_fill_half got %0b exp 0", fill_half); else n_pass++;
    endtask

    task automatic test_prime_exit();
        pause_pulse();
        n_chk++; if (fill_half !== 1'b1) $display("FAIL prime_exit_fill_half got %0b exp 1", fill_half); else n_pass++;
        wait_re();
        n_chk++; if (ram_address !== 25'h0) $display("FAIL first_addr got %0h exp 0", ram_address); else n_pass++;
        n_chk++; if (rd_half !== 1'b0) $display("FAIL first_rd_half got %0b exp 0", rd_half); else n_pass++;
    endtask

    task automatic test_stream();
        int g0, v0;
        cyc(30);
        g0 = got.size(); v0 = n_valid;
        for (int k = 0; k < 16; k++) begin tick(); cyc(5); end
        cyc(3);
        n_chk++; if (n_valid - v0 !== 16) $display("FAIL stream_count got %0d exp 16", n_valid - v0); else n_pass++;
        if (got.size() >= g0 + 16)
            for (int k = 0; k < 16; k++) begin
                n_chk++;
                if (got[g0+k] !== 16'(k)) $display("FAIL stream_data[%0d] got %0h exp %0h", k, got[g0+k], 16'(k));
                else n_pass++;
            end
        n_chk++; if (underrun !== 1'b0) $display("FAIL stream_underrun got %0b exp 0", underrun); else n_pass++;
    endtask

    task automatic test_swap();
        int r0;
        r0 = n_re;
        cyc(30);
        n_chk++; if (n_re - r0 !== 0) $display("FAIL swap_wait_ram_re got %0d exp 0", n_re - r0); else n_pass++;
        n_chk++; if (fill_half !== 1'b1) $display("FAIL swap_wait_fill_half got %0b exp 1", fill_half); else n_pass++;
        pause_pulse();
        n_chk++; if (fill_half !== 1'b0) $display("FAIL swap_fill_half got %0b exp 0", fill_half); else n_pass++;
        n_chk++; if (rd_half !== 1'b1) $display("FAIL swap_rd_half got %0b exp 1", rd_half); else n_pass++;
        wait_re();
        n_chk++; if (ram_address !== UB) $display("FAIL swap_addr got %0h exp %0h", ram_address, UB); else n_pass++;
    endtask

    task automatic test_underrun();
        int g0;
        cyc(20);
        lat = 5;
        g0 = got.size();
        sample_tick = 1'b1;
        cyc(16);
        sample_tick = 1'b0;
        cyc(2);
        n_up = got.size() - g0;
        n_chk++; if (underrun !== 1'b1) $display("FAIL underrun_flag got %0b exp 1", underrun); else n_pass++;
        n_chk++; if (n_up < 4) $display("FAIL underrun_drained got %0d exp >=4", n_up); else n_pass++;
        for (int k = 0; k < n_up; k++) begin
            n_chk++;
            if (got[g0+k] !== 16'(32'h100 + k)) $display("FAIL underrun_seq[%0d] got %0h exp %0h", k, got[g0+k], 16'(32'h100 + k));
            else n_pass++;
        end
        n_chk++;
        if (sample_out !== 16'(32'h100 + n_up - 1)) $display("FAIL underrun_hold got %0h exp %0h", sample_out, 16'(32'h100 + n_up - 1));
        else n_pass++;
    endtask

    task automatic test_enable_hold();
        int v0, r0;
        lat = 1;
        cyc(40);
        v0 = n_valid; r0 = n_re;
        enable = 1'b0;
        repeat (20) begin tick(); cyc(4); end
        n_chk++; if (n_re - r0 !== 0) $display("FAIL hold_ram_re got %0d exp 0", n_re - r0); else n_pass++;
        n_chk++; if (n_valid - v0 !== 0) $display("FAIL hold_valid got %0d exp 0", n_valid - v0); else n_pass++;
        n_chk++; if (sample_out !== 16'(32'h100 + n_up - 1)) $display("FAIL hold_sample got %0h exp %0h", sample_out, 16'(32'h100 + n_up - 1)); else n_pass++;
        n_chk++; if (underrun !== 1'b1) $display("FAIL hold_sticky got %0b exp 1", underrun); else n_pass++;
        enable = 1'b1;
        tick();
        cyc(2);
        n_chk++; if (n_valid - v0 !== 1) $display("FAIL resume_valid got %0d exp 1", n_valid - v0); else n_pass++;
        n_chk++; if (sample_out !== 16'(32'h100 + n_up)) $display("FAIL resume_sample got %0h exp %0h", sample_out, 16'(32'h100 + n_up)); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        int v0, g0;
        lat = 5;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ram_op_begun) begin seen = 1'b1; break; end
            cyc(1);
        end
        n_chk++; if (seen !== 1'b1) $display("FAIL midread_op_begun timeout got %0b exp 1", seen); else n_pass++;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(10);
        n_chk++; if (fill_half !== 1'b0) $display("FAIL midread_fill_half got %0b exp 0", fill_half); else n_pass++;
        n_chk++; if (rd_half !== 1'b0) $display("FAIL midread_rd_half got %0b exp 0", rd_half); else n_pass++;
        n_chk++; if (ram_re !== 1'b0) $display("FAIL midread_ram_re got %0b exp 0", ram_re); else n_pass++;
        n_chk++; if (underrun !== 1'b0) $display("FAIL midread_underrun got %0b exp 0", underrun); else n_pass++;
        n_chk++; if (sample_out !== 16'h0) $display("FAIL midread_sample got %0h exp 0", sample_out); else n_pass++;
        v0 = n_valid;
        tick();
        cyc(2);
        n_chk++; if (n_valid - v0 !== 0) $display("FAIL midread_prime_valid got %0d exp 0", n_valid - v0); else n_pass++;
        n_chk++; if (underrun !== 1'b0) $display("FAIL midread_prime_underrun got %0b exp 0", underrun); else n_pass++;
        lat = 1;
        pause_pulse();
        wait_re();
        n_chk++; if (ram_address !== 25'h0) $display("FAIL midread_restart_addr got %0h exp 0", ram_address); else n_pass++;
        cyc(20);
        g0 = got.size();
        tick();
        cyc(2);
        n_chk++;
        if (got.size() != g0 + 1) $display("FAIL midread_first_count got %0d exp 1", got.size() - g0);
        else if (got[g0] !== 16'h0) $display("FAIL midread_first_sample got %0h exp 0", got[g0]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_prime_ticks();
        test_prime_exit();
        test_stream();
        test_swap();
        test_underrun();
        test_enable_hold();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
